uni_count_ctrl: RTL and testbench

//  Command-driven master for the universal up/down/load counter interface.

---
 rtl/uni_count_ctrl_if.sv | 26 ++
 rtl/uni_count_ctrl.sv | 157 +++++++++++++++
 tb/tb_uni_count_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uni_count_ctrl_if.sv
// Command / response handshake bundle for the universal counter controller.
// The master offers commands and accepts responses; the slave is the controller.
interface uni_count_ctrl_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_data;
  logic [STEP_W-1:0] cmd_steps;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_value;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_value, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps, rsp_ready,
    output cmd_ready, rsp_valid, rsp_value, rsp_err
  );
endinterface

// File: rtl/uni_count_ctrl.sv
// Command-driven master for an up/down/load counter. Runs one LOAD, COUNT or NOP
// per command, then reads the counter back and reports value plus mismatch flag.
module uni_count_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  uni_count_ctrl_if.slave  bus,
  output logic             count_en,
  output logic             load_en,
  output logic             up_down,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] q_out,
  output logic             busy
);

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpUp   = 2'b10;
  localparam logic [1:0] OpDown = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StCount, StChk, StResp} state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] remain_q, remain_d;
  logic [WIDTH-1:0]  expect_q, expect_d;
  logic              count_en_q, count_en_d;
  logic              load_en_q, load_en_d;
  logic              up_down_q, up_down_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_value_q, rsp_value_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;

  // Steps reduced mod 2^WIDTH; the counter wraps, so only the low bits matter.
  logic [WIDTH-1:0]  steps_mod;
  assign steps_mod = WIDTH'(bus.cmd_steps);

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    expect_d    = expect_q;
    count_en_d  = count_en_q;
    load_en_d   = load_en_q;
    up_down_d   = up_down_q;
    data_in_d   = data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_value_d = rsp_value_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          unique case (bus.cmd_op)
            OpLoad: begin
              state_d   = StLoad;
              load_en_d = 1'b1;
              data_in_d = bus.cmd_data;
              expect_d  = bus.cmd_data;
            end
            OpUp, OpDown: begin
              up_down_d = (bus.cmd_op == OpUp);
              expect_d  = (bus.cmd_op == OpUp) ? q_out + steps_mod : q_out - steps_mod;
              if (bus.cmd_steps == '0) begin
                state_d = StChk;
              end else begin
                state_d    = StCount;
                count_en_d = 1'b1;
                remain_d   = bus.cmd_steps;
              end
            end
            OpNop: begin
              expect_d = q_out;
              state_d  = StChk;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StLoad: begin
        load_en_d = 1'b0;
        state_d   = StChk;
      end
      StCount: begin
        // remain_q counts enable cycles still owed including the current one.
        if (remain_q == STEP_W'(1)) begin
          count_en_d = 1'b0;
          state_d    = StChk;
        end else begin
          remain_d = remain_q - STEP_W'(1);
        end
      end
      StChk: begin
        rsp_valid_d = 1'b1;
        rsp_value_d = q_out;
        rsp_err_d   = (q_out != expect_q);
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      remain_q    <= '0;
      expect_q    <= '0;
      count_en_q  <= 1'b0;
      load_en_q   <= 1'b0;
      up_down_q   <= 1'b1;
      data_in_q   <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_value_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      expect_q    <= expect_d;
      count_en_q  <= count_en_d;
      load_en_q   <= load_en_d;
      up_down_q   <= up_down_d;
      data_in_q   <= data_in_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_value_q <= rsp_value_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign count_en      = count_en_q;
  assign load_en       = load_en_q;
  assign up_down       = up_down_q;
  assign data_in       = data_in_q;
  assign busy          = busy_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uni_count_ctrl.sv
// Bench for uni_count_ctrl: behavioural counter, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uni_count_ctrl;
  localparam int unsigned W   = 4;
  localparam int unsigned SW  = 8;
  localparam int          MOD = 1 << W;
  localparam logic [1:0]  OP_NOP  = 2'b00;
  localparam logic [1:0]  OP_LOAD = 2'b01;
  localparam logic [1:0]  OP_UP   = 2'b10;
  localparam logic [1:0]  OP_DOWN = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uni_count_ctrl_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  logic         count_en, load_en, up_down, busy;
  logic [W-1:0] data_in, q_out;

  uni_count_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .count_en (count_en),
    .load_en  (load_en),
    .up_down  (up_down),
    .data_in  (data_in),
    .q_out    (q_out),
    .busy     (busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural counter; skip_pulses drops count enables to emulate a faulty counter.
  logic [W-1:0] cnt_q = '0;
  int skip_pulses = 0;
  always @(posedge clk) begin
    if (load_en === 1'b1) cnt_q <= data_in;
    else if (count_en === 1'b1) begin
      if (skip_pulses > 0) skip_pulses--;
      else cnt_q <= (up_down === 1'b1) ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
  end
  assign q_out = cnt_q;

  // Transaction-level reference: m_k = edges since the accept edge.
  bit           m_live = 0;
  bit           m_busy = 0;
  int           m_k = 0, m_lat = 0, m_n = 0;
  logic [1:0]   m_op = OP_NOP;
  logic [W-1:0] m_exp = '0, m_val = '0, m_data = '0;
  bit           m_err = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_live = 1;
      m_busy = 0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (bus.cmd_valid === 1'b1) begin
          m_busy = 1;
          m_k    = 0;
          m_op   = bus.cmd_op;
          m_n    = int'(bus.cmd_steps);
          m_data = bus.cmd_data;
          case (m_op)
            OP_LOAD: begin m_exp = bus.cmd_data; m_lat = 2; end
            OP_UP: begin
              m_exp = W'((int'(cnt_q) + m_n) % MOD);
              m_lat = m_n + 1;
            end
            OP_DOWN: begin
              m_exp = W'(((int'(cnt_q) - m_n) % MOD + MOD) % MOD);
              m_lat = m_n + 1;
            end
            default: begin m_exp = cnt_q; m_lat = 1; end
          endcase
        end
      end else if (m_k >= m_lat && bus.rsp_ready === 1'b1) begin
        m_busy = 0;
      end else begin
        m_k++;
        if (m_k == m_lat) begin
          m_val = cnt_q;
          m_err = (cnt_q != m_exp);
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the reference.
  always @(negedge clk) begin
    if (m_live) begin
      bit exp_load, exp_cnt, exp_rv;
      exp_load = m_busy && m_op == OP_LOAD && m_k == 0;
      exp_cnt  = m_busy && m_op[1] && m_k < m_n;
      exp_rv   = m_busy && m_k >= m_lat;
      check("cmd_ready", bus.cmd_ready, !m_busy);
      check("busy", busy, m_busy);
      check("load_en", load_en, exp_load);
      if (exp_load) check("data_in", data_in, m_data);
      check("count_en", count_en, exp_cnt);
      if (exp_cnt) check("up_down", up_down, m_op == OP_UP);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rsp_value", bus.rsp_value, m_val);
        check("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  int ce_cycles = 0, le_cycles = 0;
  always @(negedge clk) begin
    if (count_en === 1'b1) ce_cycles++;
    if (load_en === 1'b1) le_cycles++;
  end

  // Offer a command and return just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input int steps);
    int i;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_steps = SW'(steps);
    for (i = 0; i < 100; i++) begin
      if (bus.cmd_ready === 1'b1) break;
      @(posedge clk); #1;
    end
    check("cmd_ready_at_offer", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for the response (edges counted from accept), hold, then accept it.
  task automatic get_rsp(input int hold, input bit noise, output logic [W-1:0] val,
                         output logic err, output int lat);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 400) begin
      if (noise) begin
        bus.cmd_valid = 1'($urandom);
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = W'($urandom);
        bus.cmd_steps = SW'($urandom);
        bus.rsp_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_seen", bus.rsp_valid, 1);
    val = bus.rsp_value;
    err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v;
    logic         e;
    int           lat, op, steps, fault, hold, exp_lat;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    bus.cmd_steps = '0;
    bus.rsp_ready = 1'b0;

    // Reset held two cycles.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count_en", count_en, 0);
    check("rst_load_en", load_en, 0);
    check("rst_up_down", up_down, 1);
    check("rst_data_in", data_in, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_value", bus.rsp_value, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // LOAD 2.
    le_cycles = 0;
    send(OP_LOAD, 4'd2, 0);
    check("t2_load_en", load_en, 1);
    check("t2_data_in", data_in, 2);
    get_rsp(0, 0, v, e, lat);
    check("t2_latency", lat, 2);
    check("t2_value", v, 2);
    check("t2_err", e, 0);
    check("t2_load_cycles", le_cycles, 1);

    // LOAD 14, COUNT_UP 3 wraps to 1.
    send(OP_LOAD, 4'd14, 0);
    get_rsp(0, 0, v, e, lat);
    check("t3_load_value", v, 14);
    ce_cycles = 0;
    send(OP_UP, 4'd0, 3);
    check("t3_up_down", up_down, 1);
    get_rsp(0, 0, v, e, lat);
    check("t3_latency", lat, 4);
    check("t3_value", v, 1);
    check("t3_err", e, 0);
    check("t3_count_cycles", ce_cycles, 3);

    // LOAD 1, COUNT_DOWN 2 -> 15; COUNT_UP 0 -> no pulse, 1-edge latency.
    send(OP_LOAD, 4'd1, 0);
    get_rsp(0, 0, v, e, lat);
    send(OP_DOWN, 4'd0, 2);
    check("t4_up_down", up_down, 0);
    get_rsp(0, 0, v, e, lat);
    check("t4_down_value", v, 15);
    check("t4_down_err", e, 0);
    ce_cycles = 0;
    send(OP_UP, 4'd0, 0);
    get_rsp(0, 0, v, e, lat);
    check("t4_zero_latency", lat, 1);
    check("t4_zero_value", v, 15);
    check("t4_zero_err", e, 0);
    check("t4_zero_pulses", ce_cycles, 0);

    // Counter drops one pulse; response must flag it and hold while unaccepted.
    send(OP_LOAD, 4'd0, 0);
    get_rsp(0, 0, v, e, lat);
    skip_pulses = 1;
    send(OP_UP, 4'd0, 5);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("t5_latency", lat, 6);
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", bus.rsp_valid, 1);
      check("t5_hold_value", bus.rsp_value, 4);
      check("t5_hold_err", bus.rsp_err, 1);
      check("t5_hold_cmd_ready", bus.cmd_ready, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("t5_after_accept_ready", bus.cmd_ready, 1);
    check("t5_after_accept_valid", bus.rsp_valid, 0);

    // Reset in the second cycle of an 8-step burst.
    send(OP_UP, 4'd0, 8);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t6_count_en_dropped", count_en, 0);
    check("t6_no_rsp", bus.rsp_valid, 0);
    check("t6_busy", busy, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("t6_no_late_rsp", bus.rsp_valid, 0);
    end
    le_cycles = 0;
    send(OP_LOAD, 4'd7, 0);
    check("t6_load_en", load_en, 1);
    check("t6_data_in", data_in, 7);
    get_rsp(0, 0, v, e, lat);
    check("t6_latency", lat, 2);
    check("t6_value", v, 7);
    check("t6_err", e, 0);
    check("t6_load_cycles", le_cycles, 1);

    // Random traffic with noise on ignored inputs.
    for (int n = 0; n < 80; n++) begin
      op    = int'($urandom_range(0, 3));
      steps = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 40))
                                          : int'($urandom_range(0, 6));
      fault = (op >= 2 && steps > 0 && $urandom_range(0, 7) == 0) ? 1 : 0;
      hold  = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      skip_pulses = fault;
      ce_cycles = 0;
      send(2'(op), W'($urandom), steps);
      get_rsp(hold, 1, v, e, lat);
      exp_lat = (op == 1) ? 2 : (op >= 2) ? steps + 1 : 1;
      check("rand_latency", lat, exp_lat);
      check("rand_err", e, fault);
      check("rand_count_cycles", ce_cycles, (op >= 2) ? steps : 0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
